// File: rtl/branch_pkg.sv
// Shared counter encodings, entry layout and PC field extraction for the branch predictor.
package branch_pkg;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_TAG_BITS = 8;
    localparam int DEF_CTR_BITS = 2;

    // Entry layout at the default configuration.
    typedef struct packed {
        logic                    valid;
        logic [DEF_TAG_BITS-1:0] tag;
        logic [DEF_XLEN-1:0]     target;
        logic [DEF_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    // Word-aligned PCs: bits [1:0] never contribute to index or tag.
    function automatic int unsigned btb_index(input logic [63:0] pc, input int idx_bits);
        return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

    function automatic int unsigned btb_tag(input logic [63:0] pc, input int idx_bits,
                                            input int tag_bits);
        return 32'((pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1));
    endfunction

endpackage

// File: rtl/branch_btb_array.sv
// BTB storage: flop-based entries with two combinational read ports and one write port.
module branch_btb_array #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] fetch_idx_i,
    output logic                fetch_valid_o,
    output logic [TAG_BITS-1:0] fetch_tag_o,
    output logic [XLEN-1:0]     fetch_target_o,
    output logic [CTR_BITS-1:0] fetch_ctr_o,
    input  logic [IDX_BITS-1:0] res_idx_i,
    output logic                res_valid_o,
    output logic [TAG_BITS-1:0] res_tag_o,
    output logic [XLEN-1:0]     res_target_o,
    output logic [CTR_BITS-1:0] res_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [XLEN-1:0]     wr_target_i,
    input  logic [CTR_BITS-1:0] wr_ctr_i
);

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // Every write leaves the entry valid (hit update or install); reads see pre-write state.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= '0;
                end else if (wr_en_i && wr_idx_i == IDX_BITS'(gi)) begin
                    valid_q[gi]  <= 1'b1;
                    tag_q[gi]    <= wr_tag_i;
                    target_q[gi] <= wr_target_i;
                    ctr_q[gi]    <= wr_ctr_i;
                end
            end
        end
    endgenerate

    assign fetch_valid_o  = valid_q[fetch_idx_i];
    assign fetch_tag_o    = tag_q[fetch_idx_i];
    assign fetch_target_o = target_q[fetch_idx_i];
    assign fetch_ctr_o    = ctr_q[fetch_idx_i];

    assign res_valid_o    = valid_q[res_idx_i];
    assign res_tag_o      = tag_q[res_idx_i];
    assign res_target_o   = target_q[res_idx_i];
    assign res_ctr_o      = ctr_q[res_idx_i];

endmodule

// File: rtl/branch_predict_unit.sv
// BTB-based branch predictor/resolver with registered prediction and same-cycle redirect.
// Optional BRANCH_PRED_STATS_EN adds resolved-branch and mispredict counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [IDX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0] f_tag, r_tag;
    logic                f_ent_valid, r_ent_valid;
    logic [TAG_BITS-1:0] f_ent_tag, r_ent_tag;
    logic [XLEN-1:0]     f_ent_target, r_ent_target;
    logic [CTR_BITS-1:0] f_ent_ctr, r_ent_ctr;

    logic                wr_en;
    logic [XLEN-1:0]     wr_target;
    logic [CTR_BITS-1:0] wr_ctr;

    assign f_idx = IDX_BITS'(btb_index(64'(fetch_pc), IDX_BITS));
    assign f_tag = TAG_BITS'(btb_tag(64'(fetch_pc), IDX_BITS, TAG_BITS));
    assign r_idx = IDX_BITS'(btb_index(64'(res_pc), IDX_BITS));
    assign r_tag = TAG_BITS'(btb_tag(64'(res_pc), IDX_BITS, TAG_BITS));

    branch_btb_array #(
        .XLEN     (XLEN),
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clk            (clk),
        .rst            (rst),
        .fetch_idx_i    (f_idx),
        .fetch_valid_o  (f_ent_valid),
        .fetch_tag_o    (f_ent_tag),
        .fetch_target_o (f_ent_target),
        .fetch_ctr_o    (f_ent_ctr),
        .res_idx_i      (r_idx),
        .res_valid_o    (r_ent_valid),
        .res_tag_o      (r_ent_tag),
        .res_target_o   (r_ent_target),
        .res_ctr_o      (r_ent_ctr),
        .wr_en_i        (wr_en),
        .wr_idx_i       (r_idx),
        .wr_tag_i       (r_tag),
        .wr_target_i    (wr_target),
        .wr_ctr_i       (wr_ctr)
    );

    // Mispredict / redirect
    assign mispredict  = res_valid && ((res_taken != res_pred_taken) ||
                                       (res_taken && (res_target != res_pred_target)));
    assign redirect_pc = mispredict ? (res_taken ? res_target : res_pc + XLEN'(4)) : '0;

    // Training: hits move the counter, taken misses install a weakly-taken entry.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = r_ent_target;
        wr_ctr    = r_ent_ctr;
        if (res_valid) begin
            if (r_ent_valid && r_ent_tag == r_tag) begin
                wr_en = 1'b1;
                if (res_taken) begin
                    wr_ctr    = (r_ent_ctr == CTR_MAX) ? r_ent_ctr : r_ent_ctr + CTR_BITS'(1);
                    wr_target = res_target;
                end else begin
                    wr_ctr = (r_ent_ctr == '0) ? r_ent_ctr : r_ent_ctr - CTR_BITS'(1);
                end
            end else if (res_taken) begin
                wr_en     = 1'b1;
                wr_target = res_target;
                wr_ctr    = CTR_WEAK_T;
            end
        end
    end

    // Prediction register
    logic            pred_valid_q, pred_valid_d;
    logic [XLEN-1:0] pred_pc_q, pred_pc_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;
    logic            f_taken;

    assign f_taken = f_ent_valid && (f_ent_tag == f_tag) && f_ent_ctr[CTR_BITS-1];

    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_pc_d     = pred_pc_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (!stall) begin
            if (mispredict) begin
                pred_valid_d = 1'b0;
            end else begin
                pred_valid_d  = fetch_valid;
                pred_pc_d     = fetch_pc;
                pred_taken_d  = f_taken;
                pred_target_d = f_taken ? f_ent_target : fetch_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_pc_q     <= pred_pc_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_pc     = pred_pc_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    assign stat_br_d = stat_br_q + (res_valid ? 32'd1 : 32'd0);
    assign stat_mp_d = stat_mp_q + (mispredict ? 32'd1 : 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit against a table-level reference model.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predict_unit #(
        .XLEN(32), .ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-index entry plus expected prediction register and stats.
    bit          m_v   [64];
    logic [7:0]  m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    bit          e_pv;
    logic [31:0] e_pc, e_tgt;
    bit          e_tk;
    logic [31:0] m_br, m_mp;
    bit          obs_mp;
    logic [31:0] obs_rdr;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic [7:0] tag_of(input logic [31:0] pc);
        return 8'((pc / 256) % 256);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        e_pv = 0; e_pc = '0; e_tgt = '0; e_tk = 0; m_br = '0; m_mp = '0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int i = idx_of(pc);
        bit hit = m_v[i] && (m_tag[i] == tag_of(pc));
        tk = hit && (m_ctr[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_train(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        int i = idx_of(pc);
        if (m_v[i] && m_tag[i] == tag_of(pc)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tg;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_v[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tg; m_ctr[i] = 2;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_PRED_STATS_EN
        check({tag, "_stat_br"}, 64'(stat_branches), 64'(m_br));
        check({tag, "_stat_mp"}, 64'(stat_mispredicts), 64'(m_mp));
`else
        check({tag, "_stat_br"}, 64'(stat_branches), 64'd0);
        check({tag, "_stat_mp"}, 64'(stat_mispredicts), 64'd0);
`endif
    endtask

    task automatic step(input bit fv, input logic [31:0] fpc,
                        input bit rv, input logic [31:0] rpc, input bit rt,
                        input logic [31:0] rtg, input bit rpt, input logic [31:0] rptg,
                        input bit st);
        bit          mp, ptk;
        logic [31:0] ptg, rdr;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = fpc; stall = st;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
        res_pred_taken = rpt; res_pred_target = rptg;
        #1;
        mp  = rv && ((rt != rpt) || (rt && rtg != rptg));
        rdr = rt ? rtg : rpc + 32'd4;
        obs_mp = mispredict; obs_rdr = redirect_pc;
        check("mispredict", 64'(mispredict), 64'(mp));
        if (mp) check("redirect_pc", 64'(redirect_pc), 64'(rdr));
        model_predict(fpc, ptk, ptg);
        if (!st) begin
            if (mp) e_pv = 0;
            else begin e_pv = fv; e_pc = fpc; e_tk = ptk; e_tgt = ptg; end
        end
        if (rv) model_train(rpc, rt, rtg);
        if (rv) m_br = m_br + 32'd1;
        if (mp) m_mp = m_mp + 32'd1;
        @(posedge clk);
        #1;
        check("pred_valid", 64'(pred_valid), 64'(e_pv));
        if (e_pv) begin
            check("pred_pc", 64'(pred_pc), 64'(e_pc));
            check("pred_taken", 64'(pred_taken), 64'(e_tk));
            check("pred_target", 64'(pred_target), 64'(e_tgt));
        end
        check_stats("step");
        txn++;
        $display("txn %0d: fetch=%0b/%h res=%0b/%h tk=%0b mp=%0b -> pv=%0b tk=%0b tgt=%h",
                 txn, fv, fpc, rv, rpc, rt, mispredict, pred_valid, pred_taken, pred_target);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1, pc, 0, '0, 0, '0, 0, '0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                           input bit ptk, input logic [31:0] ptg);
        step(0, '0, 1, pc, tk, tg, ptk, ptg, 0);
    endtask

    logic [31:0] pc_pool [6];
    logic [31:0] tg_pool [3];

    initial begin
        pc_pool[0] = 32'h100;  pc_pool[1] = 32'h1100; pc_pool[2] = 32'h104;
        pc_pool[3] = 32'h2100; pc_pool[4] = 32'hFFFF_FFFC; pc_pool[5] = 32'h140;
        tg_pool[0] = 32'h200;  tg_pool[1] = 32'h300;  tg_pool[2] = 32'h140;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pred_valid", 64'(pred_valid), 64'd0);
        check("rst_pred_pc", 64'(pred_pc), 64'd0);
        check("rst_pred_taken", 64'(pred_taken), 64'd0);
        check("rst_pred_target", 64'(pred_target), 64'd0);
        check_stats("rst");

        fetch(32'h100);
        check("cold_taken", 64'(pred_taken), 64'd0);
        check("cold_target", 64'(pred_target), 64'h104);
        fetch(32'hFFFF_FFFC);
        check("wrap_target", 64'(pred_target), 64'h0);

        resolve(32'h100, 1, 32'h200, 0, '0);
        check("install_mp", 64'(obs_mp), 64'd1);
        check("install_redirect", 64'(obs_rdr), 64'h200);
        fetch(32'h100);
        check("install_target", 64'(pred_target), 64'h200);

        repeat (3) resolve(32'h100, 1, 32'h200, 1, 32'h200);
        resolve(32'h100, 0, '0, 1, 32'h200);
        check("nt_redirect", 64'(obs_rdr), 64'h104);
        fetch(32'h100);
        check("sat_still_taken", 64'(pred_target), 64'h200);
        resolve(32'h100, 0, '0, 1, 32'h200);
        fetch(32'h100);
        check("sat_weak_nt", 64'(pred_target), 64'h104);

        resolve(32'h100, 1, 32'h200, 0, '0);
        resolve(32'h100, 1, 32'h200, 1, 32'h200);
        fetch(32'h1100);
        check("alias_taken", 64'(pred_taken), 64'd0);
        check("alias_target", 64'(pred_target), 64'h1104);

        step(1, 32'h100, 1, 32'h100, 0, '0, 1, 32'h200, 0);
        check("flush_valid", 64'(pred_valid), 64'd0);
        fetch(32'h100);
        check("post_flush_target", 64'(pred_target), 64'h200);
        step(1, 32'h1100, 0, '0, 0, '0, 0, '0, 1);
        check("stall_hold_pc", 64'(pred_pc), 64'h100);
        check("stall_hold_target", 64'(pred_target), 64'h200);

        // Mid-operation reset: one cycle, asynchronous assertion.
        @(negedge clk);
        fetch_valid = 0; res_valid = 0; stall = 0;
        #2 rst = 1'b1;
        #1;
        check("midrst_pred_valid", 64'(pred_valid), 64'd0);
        model_clear();
        check_stats("midrst");
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h100);
        check("midrst_taken", 64'(pred_taken), 64'd0);
        check("midrst_target", 64'(pred_target), 64'h104);

        for (int n = 0; n < 400; n++) begin
            bit          fv, rv, rt, rpt, st, mtk;
            logic [31:0] fpc, rpc, rtg, rptg, mtg;
            fv  = ($urandom_range(0, 3) != 0);
            fpc = pc_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) fpc = $urandom & 32'hFFFF_FFFC;
            rv  = ($urandom_range(0, 1) == 1);
            rpc = pc_pool[$urandom_range(0, 5)];
            rt  = ($urandom_range(0, 1) == 1);
            rtg = tg_pool[$urandom_range(0, 2)];
            model_predict(rpc, mtk, mtg);
            if ($urandom_range(0, 1) == 1) begin
                rpt = mtk; rptg = mtg;
            end else begin
                rpt = ($urandom_range(0, 1) == 1); rptg = tg_pool[$urandom_range(0, 2)];
            end
            st = ($urandom_range(0, 7) == 0);
            step(fv, fpc, rv, rpc, rt, rtg, rpt, rptg, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised branch predictor and resolver for the branch pipeline.
- Direct-mapped BTB with a tag, target and N-bit saturating counter per entry; prediction is registered one cycle after fetch.
- Accepts resolution results from branch execute, trains the table, and raises a same-cycle mispredict/redirect that the front end uses to squash.
- Replaces the always-not-taken behaviour of the current branch pipeline.

Parameters:
XLEN, 32, PC/target width
ENTRIES, 64, BTB depth; power of two, >=2; IDX_BITS = log2(ENTRIES)
TAG_BITS, 8, tag width; tag = pc[IDX_BITS+TAG_BITS+1 : IDX_BITS+2]
CTR_BITS, 2, saturating counter width; predict taken when MSB=1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold prediction register
fetch_valid  in  1  fetch_pc is a lookup request
fetch_pc  in  XLEN  PC to predict; index = pc[IDX_BITS+1:2]
pred_valid  out  1  prediction outputs valid
pred_pc  out  XLEN  PC the prediction belongs to
pred_taken  out  1  predicted direction
pred_target  out  XLEN  predicted next PC
res_valid  in  1  resolved branch/jump from execute
res_pc  in  XLEN  PC of resolved instruction
res_taken  in  1  actual direction
res_target  in  XLEN  actual taken target
res_pred_taken  in  1  direction predicted for this instruction
res_pred_target  in  XLEN  target predicted for this instruction
mispredict  out  1  squash younger instructions (combinational)
redirect_pc  out  XLEN  correct next PC when mispredict=1
stat_branches  out  32  resolved branch count
stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset (async): all entry valid bits=0; tags, targets and counters=0; pred_valid=0; pred_pc=0; pred_taken=0; pred_target=0; stat_* = 0.
- Lookup: hit = valid[idx] && tag[idx]==fetch tag.
  - pred_taken_next = hit && ctr[idx][CTR_BITS-1].
  - pred_target_next = pred_taken_next ? target[idx] : fetch_pc+4.
  - The table read is combinational from flops. The result is registered into pred_* on the next edge.
- Prediction register:
  - stall=1: holds all values.
  - Else if mispredict=1: pred_valid<=0 (flush the in-flight prediction).
  - Else: pred_valid<=fetch_valid and the other fields load.
  - Latency: 1 cycle.
- Mispredict: mispredict = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)). redirect_pc = res_taken ? res_target : res_pc+4, valid only when mispredict=1. No mispredict is raised while res_valid=0.
- Training, on res_valid; not gated by stall:
  - Hit, taken: ctr saturating +1 (max 2^CTR_BITS-1); target<=res_target.
  - Hit, not taken: ctr saturating -1 (min 0).
  - Miss, taken: install valid=1, tag, target, ctr = weakly taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Read/write collision (same idx, same cycle): lookup sees the pre-update entry (read-before-write).
- PC arithmetic (+4) wraps modulo 2^XLEN.
- Reset mid-operation clears all trained state immediately; the first fetch after reset release predicts not-taken.

Optional Feature:
- Macro BRANCH_PRED_STATS_EN.
- Defined: stat_branches increments on every res_valid cycle; stat_mispredicts increments on every mispredict cycle. Both are 32-bit, wrap at 2^32 and are not gated by stall.
- Undefined: no counter flops; both ports tied to 0.

Decomposition:
- Package branch_pkg holds:
  - Counter-state constants for CTR_BITS=2: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
  - Packed btb_entry_t {valid, tag, target, ctr}.
  - Index/tag extract functions.
- Sub-module branch_btb_array: entry storage, combinational read port, one write port with read-before-write semantics.
- Top: saturating counter update, prediction register, mispredict logic, stats.

Test Plan (ENTRIES=64, TAG_BITS=8, CTR_BITS=2):
- Cold lookup: after reset, fetch 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Install:
  - Resolve pc=0x100, taken, target=0x200, pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x200.
  - Then fetch 0x100 -> pred_taken=1, pred_target=0x200 (ctr=2).
- Saturation: from ctr=2, three taken resolves -> ctr=3. One not-taken -> ctr=2, still predicts taken. A second not-taken -> ctr=1, predicts 0x104.
- Tag alias: trained 0x100, fetch 0x1100 (same idx 0, tag 0x11 vs 0x01) -> miss, pred_taken=0, pred_target=0x1104.
- Collision/flush:
  - Fetch 0x100 while resolving 0x100 with a mispredict in the same cycle -> next cycle pred_valid=0; table updated.
  - With stall=1 on the next fetch, pred_* hold.
- Mid-op reset: train 0x100, assert rst for one cycle -> pred_valid=0 immediately; fetch 0x100 predicts not taken. With BRANCH_PRED_STATS_EN, stat_* read 0.
